// File: rtl/custom_subtractor46_2_pipe.sv
// custom_subtractor46_2_pipe
//
// Recovers a 45-bit operand from a 46-bit adder sum by subtracting a 2-bit
// value, in a three-stage borrow-rippled pipeline (16 + 16 + 14 bits).
// All stages advance together when the output slot is free or being drained.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset, clears every stage
//   in_valid       in_sum/in_b carry an operation
//   in_ready       block accepts an operation this cycle (= advance enable)
//   in_sum[45:0]   minuend
//   in_b[1:0]      subtrahend, zero-extended
//   out_valid      out_a and flags are valid
//   out_ready      downstream accepts the result
//   out_a[44:0]    low 45 bits of (in_sum - in_b) mod 2^46
//   out_underflow  in_sum < in_b
//   out_overflow   no underflow and difference >= 2^45
module custom_subtractor46_2_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [45:0] in_sum,
  input  logic [1:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [44:0] out_a,
  output logic        out_underflow,
  output logic        out_overflow
);

  // Returns {borrow_out, a - b} for a 16-bit slice.
  function automatic logic [16:0] sub_borrow16(input logic [15:0] a,
                                               input logic [15:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // Returns {borrow_out, a - b} for the 14-bit top slice.
  function automatic logic [14:0] sub_borrow14(input logic [13:0] a,
                                               input logic        b);
    return {1'b0, a} - {14'b0, b};
  endfunction

  logic adv;

  logic        vld_p0_q, vld_p1_q, vld_p2_q;
  logic        brw_p0_q, brw_p1_q, brw_p2_q;
  logic [15:0] diff_lo_p0_q, diff_lo_p1_q, diff_lo_p2_q;
  logic [29:0] sum_hi_p0_q;
  logic [15:0] diff_mid_p1_q, diff_mid_p2_q;
  logic [13:0] sum_top_p1_q;
  logic [13:0] diff_top_p2_q;

  logic [16:0] st0_d;
  logic [16:0] st1_d;
  logic [14:0] st2_d;

  // The whole pipeline moves as one; a full output slot that is not being
  // taken freezes every stage, bubbles included.
  assign adv      = ~vld_p2_q | out_ready;
  assign in_ready = adv;

  assign st0_d = sub_borrow16(in_sum[15:0], {14'b0, in_b});
  assign st1_d = sub_borrow16(sum_hi_p0_q[15:0], {15'b0, brw_p0_q});
  assign st2_d = sub_borrow14(sum_top_p1_q, brw_p1_q);

  // Stage p0: bits [15:0], remaining sum bits carried forward
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q     <= 1'b0;
      brw_p0_q     <= 1'b0;
      diff_lo_p0_q <= '0;
      sum_hi_p0_q  <= '0;
    end else if (adv) begin
      vld_p0_q     <= in_valid;
      brw_p0_q     <= st0_d[16];
      diff_lo_p0_q <= st0_d[15:0];
      sum_hi_p0_q  <= in_sum[45:16];
    end
  end

  // Stage p1: bits [31:16]
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q      <= 1'b0;
      brw_p1_q      <= 1'b0;
      diff_lo_p1_q  <= '0;
      diff_mid_p1_q <= '0;
      sum_top_p1_q  <= '0;
    end else if (adv) begin
      vld_p1_q      <= vld_p0_q;
      brw_p1_q      <= st1_d[16];
      diff_lo_p1_q  <= diff_lo_p0_q;
      diff_mid_p1_q <= st1_d[15:0];
      sum_top_p1_q  <= sum_hi_p0_q[29:16];
    end
  end

  // Stage p2: bits [45:32], final borrow is the underflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q      <= 1'b0;
      brw_p2_q      <= 1'b0;
      diff_lo_p2_q  <= '0;
      diff_mid_p2_q <= '0;
      diff_top_p2_q <= '0;
    end else if (adv) begin
      vld_p2_q      <= vld_p1_q;
      brw_p2_q      <= st2_d[14];
      diff_lo_p2_q  <= diff_lo_p1_q;
      diff_mid_p2_q <= diff_mid_p1_q;
      diff_top_p2_q <= st2_d[13:0];
    end
  end

  assign out_valid     = vld_p2_q;
  assign out_a         = {diff_top_p2_q[12:0], diff_mid_p2_q, diff_lo_p2_q};
  assign out_underflow = brw_p2_q;
  // Bit 45 of a wrapped (underflowed) result is not an overflow.
  assign out_overflow  = diff_top_p2_q[13] & ~brw_p2_q;

endmodule
